// File: rtl/ctrl_decode_stage_pkg.sv
// Shared encodings and types for the registered
// main-control decode stage.
package ctrl_pkg;

  localparam int ALUOP_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b000110;
  localparam logic [5:0] OP_BGTE  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BLE   = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BLEQ  = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BLEU  = 6'b001111;
  localparam logic [5:0] OP_BGTU  = 6'b010000;
  localparam logic [5:0] OP_SEQ   = 6'b011000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALUOP_W-1:0] ALU_R    = 5'b00010;
  localparam logic [ALUOP_W-1:0] ALU_ADDI = 5'b00011;
  localparam logic [ALUOP_W-1:0] ALU_ANDI = 5'b00100;
  localparam logic [ALUOP_W-1:0] ALU_ORI  = 5'b00101;
  localparam logic [ALUOP_W-1:0] ALU_XORI = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALU_SLTI = 5'b00111;
  localparam logic [ALUOP_W-1:0] ALU_SEQ  = 5'b01001;
  localparam logic [ALUOP_W-1:0] ALU_BEQ  = 5'b01010;
  localparam logic [ALUOP_W-1:0] ALU_BNE  = 5'b01011;
  localparam logic [ALUOP_W-1:0] ALU_BGT  = 5'b01100;
  localparam logic [ALUOP_W-1:0] ALU_BGTE = 5'b01101;
  localparam logic [ALUOP_W-1:0] ALU_BLE  = 5'b01110;
  localparam logic [ALUOP_W-1:0] ALU_BLEQ = 5'b01111;
  localparam logic [ALUOP_W-1:0] ALU_BLEU = 5'b10000;
  localparam logic [ALUOP_W-1:0] ALU_BGTU = 5'b10001;
  localparam logic [ALUOP_W-1:0] ALU_NOP  = 5'b01111;

  typedef struct packed {
    logic reg_dst;
    logic reg_write;
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic jump;
    logic jump_reg;
    logic jump_link;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    alu_op: ALU_NOP, default: '0
  };

  typedef enum logic {
    ST_RUN,
    ST_BUBBLE
  } state_e;

  function automatic logic [ALUOP_W-1:0] br_alu(
    input logic [5:0] op
  );
    case (op)
      OP_BEQ:  return ALU_BEQ;
      OP_BNE:  return ALU_BNE;
      OP_BGT:  return ALU_BGT;
      OP_BGTE: return ALU_BGTE;
      OP_BLE:  return ALU_BLE;
      OP_BLEQ: return ALU_BLEQ;
      OP_BLEU: return ALU_BLEU;
      OP_BGTU: return ALU_BGTU;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] imm_alu(
    input logic [5:0] op
  );
    case (op)
      OP_ADDI: return ALU_ADDI;
      OP_ANDI: return ALU_ANDI;
      OP_ORI:  return ALU_ORI;
      OP_XORI: return ALU_XORI;
      OP_SLTI: return ALU_SLTI;
      OP_SEQ:  return ALU_SEQ;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic is_branch(
    input logic [5:0] op
  );
    return br_alu(op) != ALU_NOP
        || op == OP_BLEQ;
  endfunction

  function automatic logic is_imm(
    input logic [5:0] op
  );
    return imm_alu(op) != ALU_NOP;
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// IF/ID-side and EX-side handshake bundle of the
// decode stage.
interface ctrl_decode_stage_if
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [REG_W-1:0]   rs;
  logic [REG_W-1:0]   rt;
  logic [REG_W-1:0]   rd;
  logic               ex_mem_read;
  logic [REG_W-1:0]   ex_wr_reg;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic               reg_dst;
  logic               reg_write;
  logic               branch;
  logic               mem_read;
  logic               mem_to_reg;
  logic               mem_write;
  logic               alu_src;
  logic               jump;
  logic               jump_reg;
  logic               jump_link;
  logic [ALUOP_W-1:0] alu_op;
  logic [REG_W-1:0]   wr_reg;
  logic               illegal;
  logic               stall;

  modport master (
    output in_valid, opcode, funct,
    output rs, rt, rd,
    output ex_mem_read, ex_wr_reg,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  reg_dst, reg_write, branch,
    input  mem_read, mem_to_reg,
    input  mem_write, alu_src, jump,
    input  jump_reg, jump_link,
    input  alu_op, wr_reg,
    input  illegal, stall
  );

  modport slave (
    input  in_valid, opcode, funct,
    input  rs, rt, rd,
    input  ex_mem_read, ex_wr_reg,
    input  flush, out_ready,
    output in_ready, out_valid,
    output reg_dst, reg_write, branch,
    output mem_read, mem_to_reg,
    output mem_write, alu_src, jump,
    output jump_reg, jump_link,
    output alu_op, wr_reg,
    output illegal, stall
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure opcode/funct to control-bundle decoder with
// destination resolution and illegal detection.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int RA_REG = 31
) (
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] rd_i,
  output ctrl_t            ctrl_o,
  output logic [REG_W-1:0] wr_reg_o,
  output logic             illegal_o,
  output logic             uses_rt_o
);

  always_comb begin
    ctrl_o    = CTRL_RST;
    wr_reg_o  = '0;
    illegal_o = 1'b0;
    uses_rt_o = 1'b0;
    unique case (1'b1)
      (opcode_i == OP_RTYPE): begin
        ctrl_o.reg_dst = 1'b1;
        ctrl_o.alu_op  = ALU_R;
        uses_rt_o      = 1'b1;
        wr_reg_o       = rd_i;
        if (funct_i == FN_JR)
          ctrl_o.jump_reg = 1'b1;
        else
          ctrl_o.reg_write = 1'b1;
      end
      (opcode_i == OP_LW): begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
        wr_reg_o          = rt_i;
      end
      (opcode_i == OP_SW): begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        uses_rt_o        = 1'b1;
      end
      is_branch(opcode_i): begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = br_alu(opcode_i);
        uses_rt_o     = 1'b1;
      end
      (opcode_i == OP_J): begin
        ctrl_o.jump = 1'b1;
      end
      (opcode_i == OP_JAL): begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.jump_link = 1'b1;
        ctrl_o.reg_write = 1'b1;
        wr_reg_o         = REG_W'(RA_REG);
      end
      is_imm(opcode_i): begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = imm_alu(opcode_i);
        wr_reg_o         = rt_i;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: hazard bubbles, flush and
// valid/ready output register toward EX.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LU_BUBBLES = 1,
  parameter int RA_REG     = 31
) (
  input logic               clk,
  input logic               rst_n,
  ctrl_decode_stage_if.slave bus
);

  localparam logic [1:0] LU_INIT =
    2'(LU_BUBBLES - 1);

  ctrl_t            dec_ctrl;
  logic [REG_W-1:0] dec_wr;
  logic             dec_ill;
  logic             uses_rt;

  ctrl_t            ctrl_q;
  logic [REG_W-1:0] wr_q;
  logic             illegal_q;
  logic             out_valid_q;
  state_e           state_q;
  logic [1:0]       cnt_q;

  logic hz;
  logic in_ready_base;
  logic accept;

  ctrl_decode_comb #(
    .REG_W  (REG_W),
    .RA_REG (RA_REG)
  ) u_dec (
    .opcode_i  (bus.opcode),
    .funct_i   (bus.funct),
    .rt_i      (bus.rt),
    .rd_i      (bus.rd),
    .ctrl_o    (dec_ctrl),
    .wr_reg_o  (dec_wr),
    .illegal_o (dec_ill),
    .uses_rt_o (uses_rt)
  );

  // r0 is never a real producer
  assign hz = bus.in_valid
            & bus.ex_mem_read
            & (bus.ex_wr_reg != '0)
            & ((bus.ex_wr_reg == bus.rs)
            | (uses_rt
            & (bus.ex_wr_reg == bus.rt)));

  assign in_ready_base =
    !out_valid_q | bus.out_ready;

  assign bus.in_ready = in_ready_base
                      & (state_q == ST_RUN)
                      & !hz
                      & !bus.flush;

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_RST;
      wr_q        <= '0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hz && in_ready_base) begin
            state_q <= ST_BUBBLE;
            cnt_q   <= LU_INIT;
          end
        end
        ST_BUBBLE: begin
          if (cnt_q == '0)
            state_q <= ST_RUN;
          else
            cnt_q <= cnt_q - 1'b1;
        end
      endcase
      if (accept) begin
        out_valid_q <= 1'b1;
        ctrl_q      <= dec_ctrl;
        wr_q        <= dec_wr;
        illegal_q   <= dec_ill;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.stall      = (state_q == ST_BUBBLE);
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.branch     = ctrl_q.branch;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.jump       = ctrl_q.jump;
  assign bus.jump_reg   = ctrl_q.jump_reg;
  assign bus.jump_link  = ctrl_q.jump_link;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.wr_reg     = wr_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: decode table
// plus stall, hold, flush and reset sequences.
module tb_ctrl_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage_if #(.REG_W(5)) bus ();

  ctrl_decode_stage #(
    .REG_W      (5),
    .LU_BUBBLES (2),
    .RA_REG     (31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [9:0] bits;
    logic [4:0] alu;
    logic       chk_alu;
    logic [4:0] wr;
    logic       ill;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(
    input string nm,
    input logic [5:0] op, fn,
    input logic [4:0] rt, rd,
    input logic [9:0] bits,
    input logic [4:0] alu,
    input logic ca,
    input logic [4:0] wr,
    input logic ill
  );
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn;
    v.rt = rt; v.rd = rd; v.bits = bits;
    v.alu = alu; v.chk_alu = ca;
    v.wr = wr; v.ill = ill;
    return v;
  endfunction

  function automatic logic [9:0] got_bits();
    return {bus.reg_dst, bus.reg_write,
            bus.branch, bus.mem_read,
            bus.mem_to_reg, bus.mem_write,
            bus.alu_src, bus.jump,
            bus.jump_reg, bus.jump_link};
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(
    input logic [5:0] op, fn,
    input logic [4:0] rs, rt, rd
  );
    bus.in_valid = 1'b1;
    bus.opcode = op; bus.funct = fn;
    bus.rs = rs; bus.rt = rt; bus.rd = rd;
  endtask

  initial begin
    // bits: rd rw br mr m2r mw as j jr jl
    vt[0]  = mk("addi", 6'b001000, 6'd0, 5, 0,
      10'b0100001000, 5'b00011, 1, 5, 0);
    vt[1]  = mk("add", 6'b000000, 6'b100000, 4, 3,
      10'b1100000000, 5'b00010, 1, 3, 0);
    vt[2]  = mk("jr", 6'b000000, 6'b001000, 0, 0,
      10'b1000000010, 5'b00010, 1, 0, 0);
    vt[3]  = mk("lw", 6'b100011, 6'd0, 7, 0,
      10'b0101101000, 5'b00000, 1, 7, 0);
    vt[4]  = mk("sw", 6'b101011, 6'd0, 0, 0,
      10'b0000011000, 5'b00000, 1, 0, 0);
    vt[5]  = mk("beq", 6'b000100, 6'd0, 0, 0,
      10'b0010000000, 5'b01010, 1, 0, 0);
    vt[6]  = mk("bgt", 6'b000110, 6'd0, 0, 0,
      10'b0010000000, 5'b01100, 1, 0, 0);
    vt[7]  = mk("bleu", 6'b001111, 6'd0, 0, 0,
      10'b0010000000, 5'b10000, 1, 0, 0);
    vt[8]  = mk("bgtu", 6'b010000, 6'd0, 0, 0,
      10'b0010000000, 5'b10001, 1, 0, 0);
    vt[9]  = mk("j", 6'b000010, 6'd0, 0, 0,
      10'b0000000100, 5'b00000, 0, 0, 0);
    vt[10] = mk("jal", 6'b000011, 6'd0, 0, 0,
      10'b0100000101, 5'b00000, 0, 31, 0);
    vt[11] = mk("andi", 6'b001100, 6'd0, 2, 0,
      10'b0100001000, 5'b00100, 1, 2, 0);
    vt[12] = mk("ori", 6'b001101, 6'd0, 3, 0,
      10'b0100001000, 5'b00101, 1, 3, 0);
    vt[13] = mk("xori", 6'b001110, 6'd0, 4, 0,
      10'b0100001000, 5'b00110, 1, 4, 0);
    vt[14] = mk("slti", 6'b001010, 6'd0, 6, 0,
      10'b0100001000, 5'b00111, 1, 6, 0);
    vt[15] = mk("illegal", 6'b111111, 6'd0, 9, 9,
      10'b0000000000, 5'b00000, 0, 0, 1);

    bus.in_valid = 1'b0; bus.opcode = '0;
    bus.funct = '0; bus.rs = '0; bus.rt = '0;
    bus.rd = '0; bus.ex_mem_read = 1'b0;
    bus.ex_wr_reg = '0; bus.flush = 1'b0;
    bus.out_ready = 1'b1;

    tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_bits", 32'(got_bits()), 0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'h0f);
    chk("rst_wr_reg", 32'(bus.wr_reg), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      set_instr(vt[i].op, vt[i].fn, 0,
                vt[i].rt, vt[i].rd);
      tick();
      chk({vt[i].name, "_valid"},
          32'(bus.out_valid), 1);
      chk({vt[i].name, "_bits"},
          32'(got_bits()), 32'(vt[i].bits));
      if (vt[i].chk_alu)
        chk({vt[i].name, "_alu"},
            32'(bus.alu_op), 32'(vt[i].alu));
      chk({vt[i].name, "_wr"},
          32'(bus.wr_reg), 32'(vt[i].wr));
      chk({vt[i].name, "_ill"},
          32'(bus.illegal), 32'(vt[i].ill));
    end

    bus.in_valid = 1'b0;
    tick();

    // rt is a destination for addi, a source for beq
    bus.ex_mem_read = 1'b1; bus.ex_wr_reg = 8;
    set_instr(6'b001000, 0, 0, 8, 0);
    #1 chk("addi_rt_nohz", 32'(bus.in_ready), 1);
    set_instr(6'b000100, 0, 0, 8, 0);
    #1 chk("beq_rt_hz", 32'(bus.in_ready), 0);

    set_instr(6'b000000, 6'b100000, 8, 1, 2);
    #1 chk("lu_hz_ready", 32'(bus.in_ready), 0);
    tick();
    bus.ex_mem_read = 1'b0;
    chk("lu_b1_stall", 32'(bus.stall), 1);
    chk("lu_b1_ready", 32'(bus.in_ready), 0);
    chk("lu_b1_valid", 32'(bus.out_valid), 0);
    tick();
    chk("lu_b2_stall", 32'(bus.stall), 1);
    chk("lu_b2_ready", 32'(bus.in_ready), 0);
    chk("lu_b2_valid", 32'(bus.out_valid), 0);
    tick();
    chk("lu_run_stall", 32'(bus.stall), 0);
    chk("lu_run_ready", 32'(bus.in_ready), 1);
    tick();
    chk("lu_acc_valid", 32'(bus.out_valid), 1);
    chk("lu_acc_wr", 32'(bus.wr_reg), 2);
    chk("lu_acc_bits", 32'(got_bits()),
        32'(10'b1100000000));

    set_instr(6'b000011, 0, 0, 0, 0);
    tick();
    bus.out_ready = 1'b0;
    set_instr(6'b001000, 0, 0, 6, 0);
    #1 chk("hold_ready0", 32'(bus.in_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_wr", 32'(bus.wr_reg), 31);
      chk("hold_jl", 32'(bus.jump_link), 1);
      chk("hold_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1 chk("release_ready", 32'(bus.in_ready), 1);
    tick();
    chk("release_valid", 32'(bus.out_valid), 1);
    chk("release_wr", 32'(bus.wr_reg), 6);
    chk("release_alu", 32'(bus.alu_op), 32'h03);

    // hazard while EX is back-pressured
    bus.out_ready = 1'b0;
    bus.ex_mem_read = 1'b1; bus.ex_wr_reg = 8;
    set_instr(6'b000000, 6'b100000, 8, 1, 2);
    tick();
    chk("hzbp_stall", 32'(bus.stall), 0);
    chk("hzbp_valid", 32'(bus.out_valid), 1);
    chk("hzbp_wr", 32'(bus.wr_reg), 6);
    bus.out_ready = 1'b1;
    tick();
    chk("hzbp_go_stall", 32'(bus.stall), 1);
    chk("hzbp_go_valid", 32'(bus.out_valid), 0);

    bus.flush = 1'b1; bus.ex_mem_read = 1'b0;
    #1 chk("flush_ready", 32'(bus.in_ready), 0);
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 0);
    chk("flush_stall", 32'(bus.stall), 0);
    #1 chk("flush_run_ready", 32'(bus.in_ready), 1);
    tick();

    bus.ex_mem_read = 1'b1; bus.ex_wr_reg = 0;
    set_instr(6'b000000, 6'b001000, 0, 0, 0);
    #1 chk("jr_r0_ready", 32'(bus.in_ready), 1);
    tick();
    chk("jr_r0_stall", 32'(bus.stall), 0);
    chk("jr_r0_valid", 32'(bus.out_valid), 1);
    chk("jr_r0_bits", 32'(got_bits()),
        32'(10'b1000000010));

    bus.ex_wr_reg = 8;
    set_instr(6'b000000, 6'b100000, 8, 1, 2);
    tick();
    chk("rstb_stall_pre", 32'(bus.stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rstb_stall", 32'(bus.stall), 0);
    chk("rstb_valid", 32'(bus.out_valid), 0);
    chk("rstb_alu", 32'(bus.alu_op), 32'h0f);
    bus.in_valid = 1'b0; bus.ex_mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstb_after_ready", 32'(bus.in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
